// File: rtl/addsub_post_normalizer.sv
// -----------------------------------------------------------------------------
// addsub_post_normalizer
//
// Iterative normalizer for the raw result of the add/subtract datapath. The
// incoming word is {carry, 24-bit significand, G, R, S}. A carry-out causes a
// single right shift with sticky preservation. Otherwise the word is shifted
// left one bit per cycle until the hidden bit (bit MANT_W-1) is set, the
// exponent floor is reached (subnormal result), or the word is zero (exact
// cancellation, reported as +0). Exponent overflow on the right shift yields
// an all-ones exponent and a zero significand.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   in_valid   in   input word valid
//   in_ready   out  block can accept a word (high only when idle)
//   in_sum     in   raw adder result, [MANT_W]=carry, [2:0]=G,R,S
//   in_exp     in   biased exponent of the larger operand (0 treated as 1)
//   in_sign    in   result sign
//   out_valid  out  normalized result valid, held until out_ready
//   out_ready  in   downstream accepts the result
//   out_mant   out  normalized significand+GRS (hidden bit at MANT_W-1)
//   out_exp    out  result exponent (0 = subnormal/zero, all-ones = overflow)
//   out_sign   out  result sign
//   out_zero   out  exact zero result
//   out_ovf    out  exponent overflow
// -----------------------------------------------------------------------------
module addsub_post_normalizer #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [MANT_W:0]   s;
    logic [EXP_W-1:0]  e;
    logic              sign;
    logic              zero;
    logic              ovf;
    logic [EXP_W-1:0]  e_inc;

    // Right shift by one that folds the two bits leaving the bottom into
    // the sticky position, so no set bit is ever lost to rounding.
    function automatic logic [MANT_W:0] shr_sticky(input logic [MANT_W:0] v);
        return {1'b0, v[MANT_W:2], v[1] | v[0]};
    endfunction

    assign e_inc = e + EXP_ONE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; SHIFT decisions follow the same priority as the
    // datapath below (carry, zero, normalized, exponent floor, shift left).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (s[MANT_W]) begin
                    if (e_inc == EXP_MAX) state_nxt = DONE;
                end else if (s == '0) begin
                    state_nxt = DONE;
                end else if (s[MANT_W-1]) begin
                    state_nxt = DONE;
                end else if (e <= EXP_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: loaded on accept, updated once per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            e    <= '0;
            sign <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s    <= in_sum;
                        e    <= (in_exp == '0) ? EXP_ONE : in_exp;
                        sign <= in_sign;
                        zero <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (s[MANT_W]) begin
                        e <= e_inc;
                        if (e_inc == EXP_MAX) begin
                            s   <= '0;
                            ovf <= 1'b1;
                        end else begin
                            s <= shr_sticky(s);
                        end
                    end else if (s == '0) begin
                        // Exact cancellation always produces +0
                        zero <= 1'b1;
                        e    <= '0;
                        sign <= 1'b0;
                    end else if (s[MANT_W-1]) begin
                        // Already normalized; hold
                    end else if (e <= EXP_ONE) begin
                        // Subnormal: stop shifting, leave significand as is
                        e <= '0;
                    end else begin
                        s <= {s[MANT_W-1:0], 1'b0};
                        e <= e - EXP_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        zero <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        out_mant  = s[MANT_W-1:0];
        out_exp   = e;
        out_sign  = sign;
        out_zero  = zero;
        out_ovf   = ovf;
    end

endmodule

// File: tb/tb_addsub_post_normalizer.sv
module tb_addsub_post_normalizer;

    typedef struct {
        logic [26:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        ovf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_sum = '0;
    logic [7:0]  in_exp = '0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [26:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        out_ovf;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   shown = 1'b0;
    exp_t sb_q[$];

    addsub_post_normalizer #(.MANT_W(27), .EXP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Edge counter and accept-edge capture
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready && !rst) acc_cyc <= cyc + 1;
    end

    // Monitor: compares each presented result against the scoreboard head
    always @(negedge clk) begin
        if (!out_valid) begin
            shown = 1'b0;
        end else begin
            chk("excl_ready_valid", in_ready, 1'b0);
            if (!shown) begin
                shown = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=mant %0h exp %0d required=no output",
                             out_mant, out_exp);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    chk("mant", out_mant, x.mant);
                    chk("exp", out_exp, x.exp);
                    chk("sign", out_sign, x.sign);
                    chk("zero", out_zero, x.zero);
                    chk("ovf", out_ovf, x.ovf);
                    chk("latency", cyc - acc_cyc + 1, x.lat);
                end
            end
        end
    end

    task automatic send(input logic [27:0] sum, input logic [7:0] ex, input logic sg,
                        input bit push, input logic [26:0] m, input logic [7:0] oe,
                        input logic os, input logic oz, input logic ov, input int lat);
        int n;
        exp_t x;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1'b1);
        end else begin
            in_sum = sum; in_exp = ex; in_sign = sg; in_valid = 1'b1;
            if (push) begin
                x.mant = m; x.exp = oe; x.sign = os; x.zero = oz; x.ovf = ov; x.lat = lat;
                sb_q.push_back(x);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mant", out_mant, 27'h0);
        chk("rst_exp", out_exp, 8'h0);
        chk("rst_zero", out_zero, 1'b0);
        chk("rst_ovf", out_ovf, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        send(28'h4000000, 8'd100, 1'b1, 1, 27'h4000000, 8'd100, 1'b1, 0, 0, 2);
        send(28'h8000003, 8'd100, 1'b0, 1, 27'h4000001, 8'd101, 1'b0, 0, 0, 3);
        send(28'h0000001, 8'd100, 1'b0, 1, 27'h4000000, 8'd74,  1'b0, 0, 0, 28);
        send(28'h0000000, 8'd50,  1'b1, 1, 27'h0000000, 8'd0,   1'b0, 1, 0, 2);
        send(28'h0000010, 8'd3,   1'b0, 1, 27'h0000040, 8'd0,   1'b0, 0, 0, 4);
        send(28'h0000010, 8'd0,   1'b1, 1, 27'h0000010, 8'd0,   1'b1, 0, 0, 2);
        send(28'hC000000, 8'd253, 1'b1, 1, 27'h6000000, 8'd254, 1'b1, 0, 0, 3);

        // Overflow, then stall the output for 5 cycles
        send(28'h8000000, 8'd254, 1'b0, 1, 27'h0000000, 8'd255, 1'b0, 0, 1, 2);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_out_valid_seen", out_valid, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_mant", out_mant, 27'h0);
            chk("hold_exp", out_exp, 8'd255);
            chk("hold_ovf", out_ovf, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_ack_valid", out_valid, 1'b0);
        chk("post_ack_ovf_clr", out_ovf, 1'b0);

        // Reset in the middle of a long left-shift sequence
        send(28'h0000001, 8'd100, 1'b0, 0, 27'h0, 8'd0, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_mant", out_mant, 27'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Recovery after reset
        send(28'h4000000, 8'd100, 1'b1, 1, 27'h4000000, 8'd100, 1'b1, 0, 0, 2);
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
